// File: rtl/sargantana_icache_pkg.sv
// Shared types and default geometry for the Sargantana icache flush controller.
package sargantana_icache_pkg;

  localparam int unsigned DEF_ICACHE_N_SETS = 64;
  localparam int unsigned DEF_ICACHE_N_WAY  = 4;

  typedef enum logic [1:0] {
    FLUSH_IDLE  = 2'd0,
    FLUSH_DRAIN = 2'd1,
    FLUSH_WALK  = 2'd2,
    FLUSH_DONE  = 2'd3
  } icache_flush_state_t;

endpackage

// File: rtl/sargantana_icache_flush_ctrl.sv
// Whole-cache invalidation sequencer for the icache valid array; also arbitrates
// the array's single write port between the invalidation walk and line fills.
module sargantana_icache_flush_ctrl
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned ICACHE_N_SETS = DEF_ICACHE_N_SETS,
  parameter int unsigned ICACHE_N_WAY  = DEF_ICACHE_N_WAY,
  parameter int unsigned INIT_ON_RESET = 1,
  localparam int unsigned SET_W        = $clog2(ICACHE_N_SETS)
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    flush_req_i,
  input  logic                    ifill_pending_i,
  input  logic                    fill_wr_i,
  input  logic [SET_W-1:0]        fill_idx_i,
  input  logic [ICACHE_N_WAY-1:0] fill_way_i,
  output logic                    fill_gnt_o,
  output logic                    vld_we_o,
  output logic [SET_W-1:0]        vld_idx_o,
  output logic [ICACHE_N_WAY-1:0] vld_way_o,
  output logic                    vld_data_o,
  output logic                    flush_busy_o,
  output logic                    flush_done_o
);

  localparam logic [SET_W-1:0] LAST_SET = SET_W'(ICACHE_N_SETS - 1);
  localparam icache_flush_state_t RST_STATE =
    (INIT_ON_RESET != 0) ? FLUSH_WALK : FLUSH_IDLE;

  icache_flush_state_t state_q, state_d;
  logic [SET_W-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    vld_we_o     = 1'b0;
    vld_idx_o    = '0;
    vld_way_o    = '0;
    vld_data_o   = 1'b0;
    flush_done_o = 1'b0;
    unique case (state_q)
      FLUSH_IDLE: begin
        // Fill writes own the port; a simultaneous flush is cleaned up by the walk that follows.
        vld_we_o   = fill_wr_i;
        vld_idx_o  = fill_idx_i;
        vld_way_o  = fill_way_i;
        vld_data_o = 1'b1;
        if (flush_req_i) begin
          state_d = ifill_pending_i ? FLUSH_DRAIN : FLUSH_WALK;
        end
      end
      FLUSH_DRAIN: begin
        if (!ifill_pending_i) begin
          state_d = FLUSH_WALK;
        end
      end
      FLUSH_WALK: begin
        vld_we_o  = 1'b1;
        vld_idx_o = cnt_q;
        vld_way_o = '1;
        // Set count is a power of two, so the increment wraps to 0 on the last set.
        cnt_d     = cnt_q + SET_W'(1);
        if (cnt_q == LAST_SET) begin
          state_d = FLUSH_DONE;
        end
      end
      FLUSH_DONE: begin
        flush_done_o = 1'b1;
        state_d      = FLUSH_IDLE;
      end
      default: state_d = FLUSH_IDLE;
    endcase
  end

  assign fill_gnt_o   = (state_q == FLUSH_IDLE);
  assign flush_busy_o = (state_q != FLUSH_IDLE);

endmodule

// File: tb/tb_sargantana_icache_flush_ctrl.sv
// Directed bench for the icache flush controller (64 sets, 4 ways), with a second
// instance built without the reset-time walk.
module tb_sargantana_icache_flush_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       flush_req;
  logic       flush_req0;
  logic       pending;
  logic       fill_wr;
  logic [5:0] fill_idx;
  logic [3:0] fill_way;

  logic       gnt1, we1, data1, busy1, done1;
  logic [5:0] idx1;
  logic [3:0] way1;
  logic       gnt0, we0, data0, busy0, done0;
  logic [5:0] idx0;
  logic [3:0] way0;

  int checks = 0;
  int errors = 0;

  wire [14:0] obs1 = {we1, idx1, way1, data1, gnt1, busy1, done1};
  wire [3:0]  ctl1 = {we1, gnt1, busy1, done1};
  wire [3:0]  ctl0 = {we0, gnt0, busy0, done0};

  always #5 clk = ~clk;

  sargantana_icache_flush_ctrl #(
    .ICACHE_N_SETS(64), .ICACHE_N_WAY(4), .INIT_ON_RESET(1)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .flush_req_i(flush_req), .ifill_pending_i(pending),
    .fill_wr_i(fill_wr), .fill_idx_i(fill_idx), .fill_way_i(fill_way),
    .fill_gnt_o(gnt1), .vld_we_o(we1), .vld_idx_o(idx1), .vld_way_o(way1),
    .vld_data_o(data1), .flush_busy_o(busy1), .flush_done_o(done1)
  );

  sargantana_icache_flush_ctrl #(
    .ICACHE_N_SETS(64), .ICACHE_N_WAY(4), .INIT_ON_RESET(0)
  ) dut_noinit (
    .clk_i(clk), .rstn_i(rstn), .flush_req_i(flush_req0), .ifill_pending_i(pending),
    .fill_wr_i(fill_wr), .fill_idx_i(fill_idx), .fill_way_i(fill_way),
    .fill_gnt_o(gnt0), .vld_we_o(we0), .vld_idx_o(idx0), .vld_way_o(way0),
    .vld_data_o(data0), .flush_busy_o(busy0), .flush_done_o(done0)
  );

  task automatic test_reset();
    rstn = 1'b1; flush_req = 1'b0; flush_req0 = 1'b0; pending = 1'b0;
    fill_wr = 1'b0; fill_idx = '0; fill_way = '0;
    #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs1 !== {1'b1, 6'd0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_init obs=%h exp=%h", obs1, {1'b1, 6'd0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0});
    end
    checks++;
    if ({ctl0, idx0, way0, data0} !== {4'b0100, 6'd0, 4'h0, 1'b1}) begin
      errors++; $display("FAIL reset_noinit got=%h exp=%h", {ctl0, idx0, way0, data0}, {4'b0100, 6'd0, 4'h0, 1'b1});
    end
  endtask

  task automatic test_init_walk();
    logic [5:0] e;
    @(posedge clk); #1 rstn = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      e = 6'(i);
      checks++;
      if (obs1 !== {1'b1, e, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0}) begin
        errors++; $display("FAIL init_walk[%0d] obs=%h exp=%h", i, obs1, {1'b1, e, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0});
      end
    end
    @(negedge clk);
    checks++;
    if (ctl1 !== 4'b0011) begin errors++; $display("FAIL init_done got=%b exp=0011", ctl1); end
    @(negedge clk);
    checks++;
    if (ctl1 !== 4'b0100) begin errors++; $display("FAIL init_idle got=%b exp=0100", ctl1); end
    checks++;
    if (ctl0 !== 4'b0100) begin errors++; $display("FAIL noinit_idle got=%b exp=0100", ctl0); end
  endtask

  task automatic test_flush();
    logic [5:0] e;
    @(posedge clk); #1 flush_req = 1'b1;
    @(posedge clk); #1 flush_req = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      e = 6'(i);
      checks++;
      if (obs1 !== {1'b1, e, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0}) begin
        errors++; $display("FAIL flush_walk[%0d] obs=%h exp=%h", i, obs1, {1'b1, e, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0});
      end
    end
    @(negedge clk);
    checks++;
    if (ctl1 !== 4'b0011) begin errors++; $display("FAIL flush_done got=%b exp=0011", ctl1); end
    @(negedge clk);
    checks++;
    if (ctl1 !== 4'b0100) begin errors++; $display("FAIL flush_idle got=%b exp=0100", ctl1); end
    @(negedge clk);
    checks++;
    if (ctl1 !== 4'b0100) begin errors++; $display("FAIL flush_no_repeat got=%b exp=0100", ctl1); end
  endtask

  task automatic test_drain();
    logic [5:0] e;
    @(posedge clk); #1 flush_req = 1'b1; pending = 1'b1;
    @(posedge clk); #1 flush_req = 1'b0;
    fill_wr = 1'b1; fill_idx = 6'd5; fill_way = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (ctl1 !== 4'b0010) begin errors++; $display("FAIL drain[%0d] got=%b exp=0010", k, ctl1); end
      @(posedge clk); #1;
      if (k == 3) pending = 1'b0;
      if (k == 4) fill_wr = 1'b0;
    end
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      e = 6'(i);
      checks++;
      if (obs1 !== {1'b1, e, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0}) begin
        errors++; $display("FAIL drain_walk[%0d] obs=%h exp=%h", i, obs1, {1'b1, e, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0});
      end
    end
    @(negedge clk);
    checks++;
    if (ctl1 !== 4'b0011) begin errors++; $display("FAIL drain_done got=%b exp=0011", ctl1); end
    @(negedge clk);
    checks++;
    if (ctl1 !== 4'b0100) begin errors++; $display("FAIL drain_idle got=%b exp=0100", ctl1); end
  endtask

  task automatic test_fill_and_flush();
    logic [5:0] e;
    @(posedge clk); #1 flush_req = 1'b1;
    fill_wr = 1'b1; fill_idx = 6'h12; fill_way = 4'b0100;
    @(negedge clk);
    checks++;
    if (obs1 !== {1'b1, 6'h12, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL fill_same_cycle obs=%h exp=%h", obs1, {1'b1, 6'h12, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0});
    end
    @(posedge clk); #1 flush_req = 1'b0; fill_wr = 1'b0; fill_idx = '0; fill_way = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      e = 6'(i);
      checks++;
      if (obs1 !== {1'b1, e, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0}) begin
        errors++; $display("FAIL fill_walk[%0d] obs=%h exp=%h", i, obs1, {1'b1, e, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0});
      end
    end
    @(negedge clk);
    checks++;
    if (ctl1 !== 4'b0011) begin errors++; $display("FAIL fill_done got=%b exp=0011", ctl1); end
    @(negedge clk);
    checks++;
    if (ctl1 !== 4'b0100) begin errors++; $display("FAIL fill_idle got=%b exp=0100", ctl1); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] e;
    @(posedge clk); #1 flush_req = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      e = 6'(i);
      checks++;
      if (obs1 !== {1'b1, e, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0}) begin
        errors++; $display("FAIL b2b_walk1[%0d] obs=%h exp=%h", i, obs1, {1'b1, e, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0});
      end
      if (i == 10) flush_req = 1'b0;
      if (i == 20) flush_req = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (ctl1 !== 4'b0011) begin errors++; $display("FAIL b2b_done1 got=%b exp=0011", ctl1); end
    @(negedge clk);
    checks++;
    if (ctl1 !== 4'b0100) begin errors++; $display("FAIL b2b_gap got=%b exp=0100", ctl1); end
    @(posedge clk); #1 flush_req = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      e = 6'(i);
      checks++;
      if (obs1 !== {1'b1, e, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0}) begin
        errors++; $display("FAIL b2b_walk2[%0d] obs=%h exp=%h", i, obs1, {1'b1, e, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0});
      end
      if (i == 5) flush_req = 1'b1;
      if (i == 6) flush_req = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (ctl1 !== 4'b0011) begin errors++; $display("FAIL b2b_done2 got=%b exp=0011", ctl1); end
    @(negedge clk);
    checks++;
    if (ctl1 !== 4'b0100) begin errors++; $display("FAIL b2b_idle got=%b exp=0100", ctl1); end
    @(negedge clk);
    checks++;
    if (ctl1 !== 4'b0100) begin errors++; $display("FAIL b2b_no_third got=%b exp=0100", ctl1); end
  endtask

  task automatic test_reset_midwalk();
    logic [5:0] e;
    @(posedge clk); #1 flush_req = 1'b1;
    @(posedge clk); #1 flush_req = 1'b0;
    for (int i = 0; i <= 30; i++) @(negedge clk);
    checks++;
    if (idx1 !== 6'd30) begin errors++; $display("FAIL mid_idx30 got=%0d exp=30", idx1); end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (obs1 !== {1'b1, 6'd0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL mid_async_reset obs=%h exp=%h", obs1, {1'b1, 6'd0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0});
    end
    checks++;
    if (ctl0 !== 4'b0100) begin errors++; $display("FAIL mid_reset_noinit got=%b exp=0100", ctl0); end
    @(posedge clk); #1 rstn = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      e = 6'(i);
      checks++;
      if (obs1 !== {1'b1, e, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0}) begin
        errors++; $display("FAIL restart_walk[%0d] obs=%h exp=%h", i, obs1, {1'b1, e, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0});
      end
      if (i == 0) begin
        checks++;
        if (ctl0 !== 4'b0100) begin errors++; $display("FAIL restart_noinit got=%b exp=0100", ctl0); end
      end
    end
    @(negedge clk);
    checks++;
    if (ctl1 !== 4'b0011) begin errors++; $display("FAIL restart_done got=%b exp=0011", ctl1); end
    @(negedge clk);
    checks++;
    if (ctl1 !== 4'b0100) begin errors++; $display("FAIL restart_idle got=%b exp=0100", ctl1); end
  endtask

  initial begin
    test_reset();
    test_init_walk();
    test_flush();
    test_drain();
    test_fill_and_flush();
    test_back_to_back();
    test_reset_midwalk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
